fp_mult_seq_ctrl: RTL and testbench



---
 rtl/fp_mult_seq_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_fp_mult_seq_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_seq_ctrl.sv
// Sequential FP32 multiplier controller: a radix-2 shift-add significand multiply followed by
// normalisation, round-to-nearest-even and packing, with valid/ready handshakes on both sides.
module fp_mult_seq_ctrl #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned EXP_WIDTH = 8,
    parameter int unsigned SIG_WIDTH = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int unsigned MW  = SIG_WIDTH + 1;
    localparam int unsigned MW1 = MW + 1;
    localparam int unsigned PW  = 2 * MW;
    localparam int unsigned EW  = EXP_WIDTH + 2;
    localparam int unsigned CW  = $clog2(MW);

    localparam logic [EXP_WIDTH-1:0] EXP_ALL1  = '1;
    localparam logic [EXP_WIDTH-1:0] EXP_MIN   = EXP_WIDTH'(1);
    localparam logic signed [EW-1:0] EXP_ONE   = EW'(1);
    localparam logic signed [EW-1:0] EXP_BIAS  = EW'((1 << (EXP_WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_OVF   = EW'((1 << EXP_WIDTH) - 1);
    localparam logic [SIG_WIDTH-1:0] SIG_ZERO  = '0;
    localparam logic [WIDTH-2:0]     MAG_ZERO  = '0;
    localparam logic [WIDTH-1:0]     QNAN      = {1'b0, EXP_ALL1, 1'b1, {(SIG_WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]        LAST_ITER = CW'(MW - 1);

    typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} fsmStateT;

    fsmStateT              state, stateNext;
    logic [PW-1:0]         prod, prodNext;
    logic [MW-1:0]         mcand, mcandNext;
    logic [MW-1:0]         mplier, mplierNext;
    logic signed [EW-1:0]  expAcc, expNext;
    logic                  signQ, signNext;
    logic                  sticky, stickyNext;
    logic [CW-1:0]         iterCnt, iterNext;
    logic [WIDTH-1:0]      resultNext;
    logic [3:0]            flagsNext;
    logic                  outValidNext, inReadyNext;

    // Operand unpack and special-value classification
    logic [EXP_WIDTH-1:0] expA, expB, effA, effB;
    logic [SIG_WIDTH-1:0] fracA, fracB;
    logic                 aExpZero, bExpZero, aExpMax, bExpMax;
    logic                 aNan, bNan, aSnan, bSnan, aInf, bInf, aZero, bZero;
    logic [MW-1:0]        sigA, sigB;
    logic signed [EW-1:0] expInit;
    logic                 prodSign;

    assign expA     = a[WIDTH-2 -: EXP_WIDTH];
    assign expB     = b[WIDTH-2 -: EXP_WIDTH];
    assign fracA    = a[SIG_WIDTH-1:0];
    assign fracB    = b[SIG_WIDTH-1:0];
    assign aExpZero = (expA == '0);
    assign bExpZero = (expB == '0);
    assign aExpMax  = (expA == EXP_ALL1);
    assign bExpMax  = (expB == EXP_ALL1);
    assign aNan     = aExpMax & (fracA != '0);
    assign bNan     = bExpMax & (fracB != '0);
    assign aSnan    = aNan & ~fracA[SIG_WIDTH-1];
    assign bSnan    = bNan & ~fracB[SIG_WIDTH-1];
    assign aInf     = aExpMax & (fracA == '0);
    assign bInf     = bExpMax & (fracB == '0);
    assign aZero    = aExpZero & (fracA == '0);
    assign bZero    = bExpZero & (fracB == '0);
    assign sigA     = {~aExpZero, fracA};
    assign sigB     = {~bExpZero, fracB};
    assign effA     = aExpZero ? EXP_MIN : expA;
    assign effB     = bExpZero ? EXP_MIN : expB;
    assign expInit  = $signed(EW'(effA)) + $signed(EW'(effB)) - EXP_BIAS;
    assign prodSign = a[WIDTH-1] ^ b[WIDTH-1];

    // One shift-add step: add the multiplicand into the upper half, then shift right
    logic [MW:0] mulAddend, mulSum;
    assign mulAddend = mplier[0] ? {1'b0, mcand} : '0;
    assign mulSum    = {1'b0, prod[PW-1:MW]} + mulAddend;

    // Round-to-nearest-even on the normalised product
    logic [MW-1:0]        mantRaw;
    logic                 guardBit, stickyAll, roundUp, inexact, isOvf, isUnf;
    logic [MW:0]          mantSum;
    logic [SIG_WIDTH-1:0] mantFin;
    logic signed [EW-1:0] expRnd;

    assign mantRaw   = prod[PW-2 -: MW];
    assign guardBit  = prod[PW-MW-2];
    assign stickyAll = (|prod[PW-MW-3:0]) | sticky;
    assign roundUp   = guardBit & (stickyAll | mantRaw[0]);
    assign mantSum   = {1'b0, mantRaw} + MW1'(roundUp);
    assign mantFin   = mantSum[MW] ? mantSum[MW-1:1] : mantSum[SIG_WIDTH-1:0];
    assign expRnd    = mantSum[MW] ? expAcc + EXP_ONE : expAcc;
    assign inexact   = guardBit | stickyAll;
    assign isOvf     = (expRnd >= EXP_OVF);
    // Results that stay below the normal range are flushed to zero
    assign isUnf     = (expRnd < EXP_ONE) | (~prod[PW-2] & (|prod));

    always_comb begin
        stateNext    = state;
        prodNext     = prod;
        mcandNext    = mcand;
        mplierNext   = mplier;
        expNext      = expAcc;
        signNext     = signQ;
        stickyNext   = sticky;
        iterNext     = iterCnt;
        resultNext   = result;
        flagsNext    = flags;
        outValidNext = out_valid;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    signNext = prodSign;
                    if (aNan || bNan) begin
                        resultNext   = QNAN;
                        flagsNext    = {aSnan | bSnan, 3'b000};
                        outValidNext = 1'b1;
                        stateNext    = DONE;
                    end else if ((aInf && bZero) || (aZero && bInf)) begin
                        resultNext   = QNAN;
                        flagsNext    = 4'b1000;
                        outValidNext = 1'b1;
                        stateNext    = DONE;
                    end else if (aInf || bInf) begin
                        resultNext   = {prodSign, EXP_ALL1, SIG_ZERO};
                        flagsNext    = 4'b0000;
                        outValidNext = 1'b1;
                        stateNext    = DONE;
                    end else if (aZero || bZero) begin
                        resultNext   = {prodSign, MAG_ZERO};
                        flagsNext    = 4'b0000;
                        outValidNext = 1'b1;
                        stateNext    = DONE;
                    end else begin
                        mcandNext  = sigA;
                        mplierNext = sigB;
                        prodNext   = '0;
                        expNext    = expInit;
                        stickyNext = 1'b0;
                        iterNext   = '0;
                        stateNext  = MUL;
                    end
                end
            end
            MUL: begin
                prodNext   = {mulSum, prod[MW-1:1]};
                mplierNext = mplier >> 1;
                iterNext   = iterCnt + CW'(1);
                if (iterCnt == LAST_ITER) begin
                    stateNext = NORM;
                end
            end
            NORM: begin
                if (prod[PW-1]) begin
                    prodNext   = {1'b0, prod[PW-1:1]};
                    stickyNext = sticky | prod[0];
                    expNext    = expAcc + EXP_ONE;
                    stateNext  = ROUND;
                end else if (!prod[PW-2] && (expAcc > EXP_ONE)) begin
                    prodNext = {prod[PW-2:0], 1'b0};
                    expNext  = expAcc - EXP_ONE;
                end else begin
                    stateNext = ROUND;
                end
            end
            ROUND: begin
                if (isOvf) begin
                    resultNext = {signQ, EXP_ALL1, SIG_ZERO};
                    flagsNext  = 4'b0101;
                end else if (isUnf) begin
                    resultNext = {signQ, MAG_ZERO};
                    flagsNext  = 4'b0011;
                end else begin
                    resultNext = {signQ, expRnd[EXP_WIDTH-1:0], mantFin};
                    flagsNext  = {3'b000, inexact};
                end
                outValidNext = 1'b1;
                stateNext    = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    outValidNext = 1'b0;
                    stateNext    = IDLE;
                end
            end
            default: begin
                outValidNext = 1'b0;
                stateNext    = IDLE;
            end
        endcase

        inReadyNext = (stateNext == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prod      <= '0;
            mcand     <= '0;
            mplier    <= '0;
            expAcc    <= '0;
            signQ     <= 1'b0;
            sticky    <= 1'b0;
            iterCnt   <= '0;
            result    <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state     <= stateNext;
            prod      <= prodNext;
            mcand     <= mcandNext;
            mplier    <= mplierNext;
            expAcc    <= expNext;
            signQ     <= signNext;
            sticky    <= stickyNext;
            iterCnt   <= iterNext;
            result    <= resultNext;
            flags     <= flagsNext;
            out_valid <= outValidNext;
            in_ready  <= inReadyNext;
        end
    end

endmodule

// File: tb/tb_fp_mult_seq_ctrl.sv
// Bench for fp_mult_seq_ctrl: directed cases with fixed expectations, then random operands
// against an integer-arithmetic reference model of the multiply, rounding and flush rules.
module tb_fp_mult_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    int errCount   = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    fp_mult_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checkCount++;
        if (obs !== expv) begin
            errCount++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: exact integer product, then normalise, round and classify
    function automatic void refModel(input logic [31:0] opA, input logic [31:0] opB,
                                     output logic [31:0] res, output logic [3:0] flg,
                                     output int lat);
        int             ea, eb, e, normCycles;
        longint unsigned ma, mb, p, mant, rem2, half;
        logic           sgn, nanA, nanB, snanA, snanB, infA, infB, zeroA, zeroB, up, inexact, tiny;
        ea    = int'(opA[30:23]);
        eb    = int'(opB[30:23]);
        sgn   = opA[31] ^ opB[31];
        nanA  = (ea == 255) && (opA[22:0] != 0);
        nanB  = (eb == 255) && (opB[22:0] != 0);
        snanA = nanA && !opA[22];
        snanB = nanB && !opB[22];
        infA  = (ea == 255) && (opA[22:0] == 0);
        infB  = (eb == 255) && (opB[22:0] == 0);
        zeroA = (ea == 0) && (opA[22:0] == 0);
        zeroB = (eb == 0) && (opB[22:0] == 0);
        lat   = 1;
        flg   = 4'b0000;
        if (nanA || nanB) begin
            res = 32'h7FC00000;
            flg = {snanA | snanB, 3'b000};
        end else if ((infA && zeroB) || (zeroA && infB)) begin
            res = 32'h7FC00000;
            flg = 4'b1000;
        end else if (infA || infB) begin
            res = {sgn, 31'h7F800000};
        end else if (zeroA || zeroB) begin
            res = {sgn, 31'h0};
        end else begin
            ma = longint'(opA[22:0]) + ((ea != 0) ? 64'd8388608 : 64'd0);
            mb = longint'(opB[22:0]) + ((eb != 0) ? 64'd8388608 : 64'd0);
            p  = ma * mb;
            e  = ((ea == 0) ? 1 : ea) + ((eb == 0) ? 1 : eb) - 127;
            normCycles = 1;
            rem2 = 0;
            if (p >= (64'd1 << 47)) begin
                rem2 = p & 64'd1;
                p    = p >> 1;
                e    = e + 1;
            end else begin
                while ((p < (64'd1 << 46)) && (e > 1)) begin
                    p = p << 1;
                    e = e - 1;
                    normCycles++;
                end
            end
            lat  = 26 + normCycles;
            tiny = (p < (64'd1 << 46));
            mant = p >> 23;
            half = 64'd1 << 23;
            rem2 = ((p & (half - 1)) << 1) + rem2;
            up   = (rem2 > half) || ((rem2 == half) && mant[0]);
            inexact = (rem2 != 0);
            mant = mant + (up ? 64'd1 : 64'd0);
            if (mant == (64'd1 << 24)) begin
                mant = mant >> 1;
                e    = e + 1;
            end
            if (e >= 255) begin
                res = {sgn, 31'h7F800000};
                flg = 4'b0101;
            end else if ((e < 1) || tiny) begin
                res = {sgn, 31'h0};
                flg = 4'b0011;
            end else begin
                res = {sgn, 8'(e), mant[22:0]};
                flg = {3'b000, inexact};
            end
        end
    endfunction

    function automatic logic [31:0] randOperand();
        int unsigned k;
        logic [31:0] r;
        logic [7:0]  e;
        logic [22:0] f;
        k = $urandom_range(0, 9);
        r = $urandom;
        f = r[22:0];
        e = 8'($urandom_range(100, 154));
        case (k)
            6: e = 8'h00;
            7: begin
                e = 8'hFF;
                case ($urandom_range(0, 3))
                    0: begin e = 8'h00; f = 23'h0; end
                    1: f = 23'h0;
                    2: f = {1'b1, r[21:0]};
                    default: f = {1'b0, r[21:1], 1'b1};
                endcase
            end
            8: e = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(1, 20)) : 8'($urandom_range(235, 254));
            9: begin
                e = 8'($urandom_range(120, 134));
                f = 23'h7FFFFF ^ 23'($urandom_range(0, 7));
            end
            default: ;
        endcase
        return {r[31], e, f};
    endfunction

    task automatic runOp(input logic [31:0] opA, input logic [31:0] opB,
                         input logic [31:0] expRes, input logic [3:0] expFlg,
                         input int expLat, input int hold, input bit readyEarly);
        int          lat;
        logic [31:0] heldRes;
        logic [3:0]  heldFlg;
        @(negedge clk);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        checkEq("in_ready before accept", 32'(in_ready), 32'd1);
        a         = opA;
        b         = opB;
        in_valid  = 1'b1;
        out_ready = readyEarly;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat      = 1;
        while (!out_valid && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        checkEq("latency", 32'(lat), 32'(expLat));
        checkEq("result", result, expRes);
        checkEq("flags", 32'(flags), 32'(expFlg));
        heldRes = result;
        heldFlg = flags;
        if (hold > 0) in_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkEq("held out_valid", 32'(out_valid), 32'd1);
            checkEq("held in_ready", 32'(in_ready), 32'd0);
            checkEq("held result", result, heldRes);
            checkEq("held flags", 32'(flags), 32'(heldFlg));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkEq("out_valid after handshake", 32'(out_valid), 32'd0);
        checkEq("in_ready after handshake", 32'(in_ready), 32'd1);
    endtask

    logic [31:0] dA   [10] = '{32'h3FC00000, 32'h3F800001, 32'h7F000000, 32'h00800000, 32'h7F800000,
                               32'h7FA00000, 32'h00400000, 32'hBF800000, 32'h80000000, 32'h3FC00000};
    logic [31:0] dB   [10] = '{32'h40000000, 32'h3F800001, 32'h7F000000, 32'h00800000, 32'h00000000,
                               32'h3F800000, 32'h4B000000, 32'h7F800000, 32'h3F800000, 32'h40000000};
    logic [31:0] dRes [10] = '{32'h40400000, 32'h3F800002, 32'h7F800000, 32'h00000000, 32'h7FC00000,
                               32'h7FC00000, 32'h0B800000, 32'hFF800000, 32'h80000000, 32'h40400000};
    logic [3:0]  dFlg [10] = '{4'h0, 4'h1, 4'h5, 4'h3, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
    int          dLat [10] = '{27, 27, 27, 27, 1, 1, 28, 1, 1, 27};
    int          dHold[10] = '{0, 0, 1, 0, 2, 0, 0, 0, 1, 5};

    initial begin
        logic [31:0] ra, rb, rRes;
        logic [3:0]  rFlg;
        int          rLat, hold;
        bit          early, sawValid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        @(negedge clk);
        @(negedge clk);
        checkEq("reset in_ready", 32'(in_ready), 32'd0);
        checkEq("reset out_valid", 32'(out_valid), 32'd0);
        checkEq("reset result", result, 32'd0);
        checkEq("reset flags", 32'(flags), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkEq("in_ready after reset", 32'(in_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            runOp(dA[i], dB[i], dRes[i], dFlg[i], dLat[i], dHold[i], (i == 0));
        end

        // Abort an operation in the middle of the multiply
        @(negedge clk);
        a        = 32'h40490FDB;
        b        = 32'h3FB504F3;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkEq("in_ready during mid-op reset", 32'(in_ready), 32'd0);
        checkEq("out_valid during mid-op reset", 32'(out_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkEq("in_ready after mid-op reset", 32'(in_ready), 32'd1);
        sawValid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        checkEq("no output after abort", 32'(sawValid), 32'd0);

        for (int n = 0; n < 60; n++) begin
            ra    = randOperand();
            rb    = randOperand();
            early = 1'($urandom_range(0, 1));
            hold  = early ? 0 : int'($urandom_range(0, 2));
            refModel(ra, rb, rRes, rFlg, rLat);
            runOp(ra, rb, rRes, rFlg, rLat, hold, early);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
